// File: rtl/div_iterative.sv
// Multicycle signed restoring divider: one quotient bit per clock, quotient truncated toward zero.
// Divide-by-zero finishes early; the single overflow case finishes at full latency.
module div_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] opa_s, opb_s;
  logic [WIDTH-1:0] rem, quo, mag_b;
  logic [WIDTH-1:0] rem_sh, quo_sh, rem_nxt, quo_nxt;
  logic             neg, ovf, fits, last, div0;
  logic [CNT_W-1:0] cnt;

  // The most negative value maps to 2^(WIDTH-1), which is representable unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return u[WIDTH-1] ? (~u + ONE) : u;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic negate);
    return negate ? (~mag + ONE) : mag;
  endfunction

  assign opa_s = data_operandA;
  assign opb_s = data_operandB;

  // rem stays below |B| <= 2^(WIDTH-1), so its MSB is always zero before the shift.
  always_comb begin
    rem_sh  = {rem[WIDTH-2:0], quo[WIDTH-1]};
    quo_sh  = {quo[WIDTH-2:0], 1'b0};
    fits    = (rem_sh >= mag_b);
    rem_nxt = fits ? (rem_sh - mag_b) : rem_sh;
    quo_nxt = {quo_sh[WIDTH-1:1], fits};
    last    = (cnt == LAST);
    div0    = (mag_b == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state)
      IDLE: if (ctrl_DIV) state_nxt = BUSY;
      BUSY: begin
        busy = 1'b1;
        if (ctrl_DIV)          state_nxt = BUSY;
        else if (div0 || last) state_nxt = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        state_nxt      = ctrl_DIV ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A start pulse in any state reloads operands, which also aborts a running division.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem            <= '0;
      quo            <= '0;
      mag_b          <= '0;
      neg            <= 1'b0;
      ovf            <= 1'b0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      rem            <= '0;
      quo            <= magnitude(opa_s);
      mag_b          <= magnitude(opb_s);
      neg            <= opa_s[WIDTH-1] ^ opb_s[WIDTH-1];
      ovf            <= (data_operandA == MIN_VAL) && (data_operandB == '1);
      cnt            <= '0;
      data_exception <= 1'b0;
    end else if (state == BUSY) begin
      if (div0) begin
        data_result    <= '0;
        data_exception <= 1'b1;
      end else begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          data_result    <= apply_sign(quo_nxt, neg);
          data_exception <= ovf;
        end
      end
    end
  end

endmodule
